// File: rtl/uart_tx_if.sv
// Byte-send handshake and serial line of uart_tx; the sender drives the master side.
interface uart_tx_if;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       tx_ready;
  logic       tx_done;
  logic       tx;

  modport master (
    output pi_data,
    output pi_flag,
    input  tx_ready,
    input  tx_done,
    input  tx
  );

  modport slave (
    input  pi_data,
    input  pi_flag,
    output tx_ready,
    output tx_done,
    output tx
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, one stop bit, registered line output.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned UART_BPS   = 9600,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  uart_tx_if.slave bus
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned BAUD_CNT_W   = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [3:0] LAST_DATA_BIT = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state,    w_state_nxt;
  logic [BAUD_CNT_W-1:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [3:0]            r_bit_cnt,  w_bit_cnt_nxt;
  logic [7:0]            r_shift,    w_shift_nxt;
  logic                  r_tx,       w_tx_nxt;
  logic                  w_bit_end;
  logic                  w_accept;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity,   w_parity_nxt;
`else
  logic                  w_unused_parity_odd;
  assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign w_bit_end = (r_baud_cnt == BAUD_LAST);
  assign w_accept  = bus.pi_flag && (r_state == S_IDLE);

  assign bus.tx       = r_tx;
  assign bus.tx_ready = (r_state == S_IDLE);
  assign bus.tx_done  = (r_state == S_STOP) && w_bit_end;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity_nxt;
`endif
    end
  end

  // The line value for the next bit is loaded on the same edge the state advances,
  // so tx changes exactly at each bit boundary with no extra cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + 1'b1;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt   = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        w_baud_cnt_nxt = '0;
        w_tx_nxt       = 1'b1;
        if (w_accept) begin
          w_state_nxt   = S_START;
          w_bit_cnt_nxt = '0;
          w_shift_nxt   = bus.pi_data;
          w_tx_nxt      = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt  = (^bus.pi_data) ^ (PARITY_ODD != 0);
`endif
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = 4'd1;
          w_tx_nxt      = r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[7:1]};
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_parity;
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt   = S_STOP;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          w_tx_nxt      = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt   = S_IDLE;
          w_bit_cnt_nxt = '0;
          w_tx_nxt      = 1'b1;
        end
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_baud_cnt_nxt = '0;
        w_bit_cnt_nxt  = '0;
        w_tx_nxt       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one default-rate frame plus a 4-cycle-per-bit
// instance exercised through a scoreboard; UART_TX_PARITY_EN adds an odd-parity instance.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int unsigned DEF_N  = 50_000_000 / 9600;
  localparam int unsigned SM_CLK = 16;
  localparam int unsigned SM_BPS = 4;
  localparam int unsigned N      = SM_CLK / SM_BPS;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int unsigned F     = FRAME_BITS * N;
  localparam int unsigned DEF_F = FRAME_BITS * DEF_N;

  typedef struct {
    logic [7:0] data;
    bit         abort;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  uart_tx_if if_def ();
  uart_tx_if if_sm ();

  uart_tx u_dut_def (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (if_def)
  );

  uart_tx #(
    .CLK_FREQ   (SM_CLK),
    .UART_BPS   (SM_BPS),
    .PARITY_ODD (0)
  ) u_dut_sm (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (if_sm)
  );

`ifdef UART_TX_PARITY_EN
  uart_tx_if if_odd ();
  uart_tx #(
    .CLK_FREQ   (SM_CLK),
    .UART_BPS   (SM_BPS),
    .PARITY_ODD (1)
  ) u_dut_odd (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (if_odd)
  );
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line value of frame bit idx: start, data LSB first, optional parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input int unsigned idx, input bit odd);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (FRAME_BITS == 11 && idx == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  // Frame monitor on the small instance: samples every negedge once a start bit appears.
  initial begin : monitor
    logic [10:0] bits;
    logic [10:0] exp_bits;
    bit          aborted;
    bit          bad_len;
    bit          done_seen;
    bit          done_bad;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && if_sm.tx === 1'b0) begin
        bits = '0; aborted = 0; bad_len = 0; done_seen = 0; done_bad = 0;
        for (int unsigned b = 0; b < FRAME_BITS && !aborted; b++) begin
          for (int unsigned k = 0; k < N; k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            if (rst_n !== 1'b1) begin
              aborted = 1;
              break;
            end
            if (k == 0) bits[b] = if_sm.tx;
            else if (if_sm.tx !== bits[b]) bad_len = 1;
            if (if_sm.tx_done === 1'b1) begin
              if (b == FRAME_BITS - 1 && k == N - 1) done_seen = 1;
              else done_bad = 1;
            end
          end
        end
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_frame", 0, 1);
        end else begin
          e = sb_q.pop_front();
          check_eq($sformatf("frame_abort_%02h", e.data), {31'd0, aborted}, {31'd0, e.abort});
          if (!aborted) begin
            exp_bits = '0;
            for (int unsigned b = 0; b < FRAME_BITS; b++) exp_bits[b] = frame_bit(e.data, b, 1'b0);
            check_eq($sformatf("frame_bits_%02h", e.data), {21'd0, bits}, {21'd0, exp_bits});
            check_eq($sformatf("bit_width_%02h", e.data), {31'd0, bad_len}, 0);
            check_eq($sformatf("done_pulse_%02h", e.data), {30'd0, done_bad, done_seen}, 32'd1);
          end else begin
            check_eq("abort_no_done", {31'd0, done_seen | done_bad}, 0);
          end
        end
      end
    end
  end

  task automatic sm_frame(input logic [7:0] d, input string tag);
    int unsigned done_at  = 0;
    int unsigned ready_at = 0;
    @(negedge clk);
    if_sm.pi_data = d;
    if_sm.pi_flag = 1'b1;
    sb_q.push_back('{data: d, abort: 1'b0});
    @(negedge clk);
    if_sm.pi_flag = 1'b0;
    check_eq({tag, "_start_latency"}, {31'd0, if_sm.tx}, 0);
    check_eq({tag, "_busy"}, {31'd0, if_sm.tx_ready}, 0);
    for (int unsigned i = 1; i <= F + 8; i++) begin
      if (i > 1) @(negedge clk);
      if (if_sm.tx_done === 1'b1 && done_at == 0) done_at = i;
      if (if_sm.tx_ready === 1'b1 && ready_at == 0) ready_at = i;
    end
    check_eq({tag, "_done_at"}, done_at, F);
    check_eq({tag, "_ready_at"}, ready_at, F + 1);
  endtask

  initial begin : main
    int unsigned done_at;
    int unsigned done2_at;
    int unsigned ready_at;
    int unsigned start2_at;
    int unsigned lows;
    int unsigned done_cnt;
    int unsigned b;
    int unsigned m;
    logic        par_bit;

    if_def.pi_data = '0; if_def.pi_flag = 1'b0;
    if_sm.pi_data  = '0; if_sm.pi_flag  = 1'b0;
`ifdef UART_TX_PARITY_EN
    if_odd.pi_data = '0; if_odd.pi_flag = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", {31'd0, if_sm.tx}, 1);
    check_eq("rst_ready", {31'd0, if_sm.tx_ready}, 1);
    check_eq("rst_done", {31'd0, if_sm.tx_done}, 0);
    check_eq("rst_def_tx", {31'd0, if_def.tx}, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Default rate, 8'h55: check first and last cycle of every bit.
    if_def.pi_data = 8'h55;
    if_def.pi_flag = 1'b1;
    @(negedge clk);
    if_def.pi_flag = 1'b0;
    done_at = 0; ready_at = 0;
    for (int unsigned i = 1; i <= DEF_F + 4; i++) begin
      if (i > 1) @(negedge clk);
      b = (i - 1) / DEF_N;
      m = (i - 1) % DEF_N;
      if (b < FRAME_BITS && (m == 0 || m == DEF_N - 1))
        check_eq($sformatf("def_bit%0d_%s", b, (m == 0) ? "first" : "last"),
                 {31'd0, if_def.tx}, {31'd0, frame_bit(8'h55, b, 1'b0)});
      if (i == DEF_F + 1) check_eq("def_idle_after", {31'd0, if_def.tx}, 1);
      if (if_def.tx_done === 1'b1 && done_at == 0) done_at = i;
      if (if_def.tx_ready === 1'b1 && ready_at == 0) ready_at = i;
    end
    check_eq("def_done_at", done_at, DEF_F);
    check_eq("def_ready_at", ready_at, DEF_F + 1);

    // Short-bit boundary and a few patterns.
    sm_frame(8'h80, "f80");
    sm_frame(8'h07, "f07");
    sm_frame(8'hC5, "fc5");

    // Back-to-back: flag held high, data changes while busy.
    @(negedge clk);
    if_sm.pi_data = 8'h00;
    if_sm.pi_flag = 1'b1;
    sb_q.push_back('{data: 8'h00, abort: 1'b0});
    sb_q.push_back('{data: 8'hFF, abort: 1'b0});
    @(negedge clk);
    if_sm.pi_data = 8'hFF;
    done_at = 0; done2_at = 0; start2_at = 0; done_cnt = 0;
    for (int unsigned i = 1; i <= 2 * F + 8; i++) begin
      if (i > 1) @(negedge clk);
      if (i == F + 1) check_eq("b2b_idle_gap", {31'd0, if_sm.tx}, 1);
      if (i > F && if_sm.tx === 1'b0 && start2_at == 0) start2_at = i;
      if (if_sm.tx_done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
        else if (done2_at == 0) done2_at = i;
      end
      if (i == F + 2) if_sm.pi_flag = 1'b0;
    end
    check_eq("b2b_done1_at", done_at, F);
    check_eq("b2b_start2_at", start2_at, F + 2);
    check_eq("b2b_done2_at", done2_at, 2 * F + 1);
    check_eq("b2b_done_cnt", done_cnt, 2);

    // Request while busy is ignored.
    @(negedge clk);
    if_sm.pi_data = 8'h0E;
    if_sm.pi_flag = 1'b1;
    sb_q.push_back('{data: 8'h0E, abort: 1'b0});
    @(negedge clk);
    if_sm.pi_flag = 1'b0;
    done_at = 0;
    for (int unsigned i = 1; i <= F + 8; i++) begin
      if (i > 1) @(negedge clk);
      if (i == F / 2) begin
        if_sm.pi_data = 8'hA3;
        if_sm.pi_flag = 1'b1;
      end
      if (i == F / 2 + 3) if_sm.pi_flag = 1'b0;
      if (if_sm.tx_done === 1'b1 && done_at == 0) done_at = i;
    end
    check_eq("busy_done_at", done_at, F);
    lows = 0;
    repeat (2 * F) begin
      @(negedge clk);
      if (if_sm.tx !== 1'b1) lows++;
    end
    check_eq("busy_no_resend", lows, 0);

    // Reset mid-frame while the line is low.
    @(negedge clk);
    if_sm.pi_data = 8'h00;
    if_sm.pi_flag = 1'b1;
    sb_q.push_back('{data: 8'h00, abort: 1'b1});
    @(negedge clk);
    if_sm.pi_flag = 1'b0;
    repeat (6 * N - 1) @(negedge clk);
    check_eq("pre_rst_tx_low", {31'd0, if_sm.tx}, 0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_tx", {31'd0, if_sm.tx}, 1);
    check_eq("rst_mid_ready", {31'd0, if_sm.tx_ready}, 1);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_sm.tx_done !== 1'b0) done_cnt++;
    end
    check_eq("rst_mid_no_done", done_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rel_tx", {31'd0, if_sm.tx}, 1);
    check_eq("rst_rel_ready", {31'd0, if_sm.tx_ready}, 1);
    sm_frame(8'h12, "f12");

`ifdef UART_TX_PARITY_EN
    // Odd parity on 8'h07 yields a 0 parity bit.
    @(negedge clk);
    if_odd.pi_data = 8'h07;
    if_odd.pi_flag = 1'b1;
    @(negedge clk);
    if_odd.pi_flag = 1'b0;
    done_at = 0; par_bit = 1'bx;
    for (int unsigned i = 1; i <= F + 4; i++) begin
      if (i > 1) @(negedge clk);
      if (i == 9 * N + 1) par_bit = if_odd.tx;
      if (if_odd.tx_done === 1'b1 && done_at == 0) done_at = i;
    end
    check_eq("odd_parity_bit", {31'd0, par_bit}, {31'd0, frame_bit(8'h07, 9, 1'b1)});
    check_eq("odd_done_at", done_at, F);
`else
    par_bit = 1'b0;
`endif

    repeat (F + 4) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
